// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if
//
// Bundles everything that crosses the boundary of the Y86-64 write-back stage
// except the clock and reset.
//
// Signal groups:
//   memory-stage result  : m_valid, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM
//   pipeline control     : w_stall, w_bubble
//   register-file ports  : dstE, valE, dstM, valM
//   status / hazard view : w_stat, w_icode, halted
//   retire counter       : retired (CNT_W bits)
//   debug                : wbState (FSM state, 0 = RUN, 1 = STOP)
//
// Control protocol:
//   m_valid marks a real instruction, and m_valid = 0 is a bubble. Nothing
//   back-pressures the memory stage from here. On every rising edge the
//   W register either captures m_*, holds (w_stall), or loads a bubble
//   (w_bubble). If w_stall and w_bubble are both high, the register holds.
//   Once W holds a non-AOK status the stage is frozen: m_*, w_stall and
//   w_bubble are ignored until reset.
//
// Modports:
//   master : the pipeline side (memory stage plus hazard unit) that drives
//            m_* and control and consumes the write ports and status.
//   slave  : the write-back stage itself.
// ---------------------------------------------------------------------------
interface wb_stage_if #(
    parameter int CNT_W = 32
);
    // memory-stage result
    logic             m_valid;
    logic [1:0]       m_stat;
    logic [3:0]       m_icode;
    logic [63:0]      m_valE;
    logic [63:0]      m_valM;
    logic [3:0]       m_dstE;
    logic [3:0]       m_dstM;

    // pipeline control
    logic             w_stall;
    logic             w_bubble;

    // register-file write ports
    logic [3:0]       dstE;
    logic [63:0]      valE;
    logic [3:0]       dstM;
    logic [63:0]      valM;

    // status
    logic [1:0]       w_stat;
    logic [3:0]       w_icode;
    logic             halted;
    logic [CNT_W-1:0] retired;

    // debug view of the freeze FSM
    logic             wbState;

    modport master (
        output m_valid, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
        output w_stall, w_bubble,
        input  dstE, valE, dstM, valM,
        input  w_stat, w_icode, halted, retired,
        input  wbState
    );

    modport slave (
        input  m_valid, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
        input  w_stall, w_bubble,
        output dstE, valE, dstM, valM,
        output w_stat, w_icode, halted, retired,
        output wbState
    );
endinterface

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//
// Write-back stage of the pipelined Y86-64 core. This is the pipeline
// register between memory and write-back, and it is the only driver of the
// register file's write ports.
//
// Behaviour:
//   - W captures the memory-stage result one cycle after it is presented.
//   - w_stall holds W and w_bubble loads a nop bubble. Stall wins when both
//     are high.
//   - An instruction with a non-AOK status never writes the register file.
//     Once it is in W the stage freezes (STOP) until reset, and halted is
//     asserted in the same cycle.
//   - popq %rsp names the same register for E and M. Only the M write
//     (the popped value) is presented.
//
// Ports:
//   clk    : pipeline clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   wb     : wb_stage_if.slave, which carries the memory-stage inputs,
//            stall/bubble control, write ports, status and counter
//
// Parameters:
//   CNT_W  : width of the retired-instruction counter
//
// Build option:
//   WB_RETIRE_CNT_EN : when defined, retired counts the instructions that
//                      leave W successfully. When undefined, retired is
//                      tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  wb
);

    localparam logic [1:0] STAT_AOK  = 2'd0;
    localparam logic [3:0] REG_NONE  = 4'hf;
    localparam logic [3:0] ICODE_NOP = 4'h1;

    // W pipeline register contents
    typedef struct packed {
        logic        valid;
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } wReg_t;

    localparam wReg_t BUBBLE = '{
        valid: 1'b0,
        stat:  STAT_AOK,
        icode: ICODE_NOP,
        valE:  64'd0,
        valM:  64'd0,
        dstE:  REG_NONE,
        dstM:  REG_NONE
    };

    // RUN: W holds an AOK instruction or a bubble.
    // STOP: W holds a faulting or halting instruction and is frozen.
    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    state_t state;
    state_t stateNext;
    wReg_t  wQ;
    wReg_t  wNext;
    wReg_t  mIn;

    // Present the memory-stage result as a W record so the capture path is a
    // single struct assignment.
    always_comb begin
        mIn       = BUBBLE;
        mIn.valid = wb.m_valid;
        mIn.stat  = wb.m_stat;
        mIn.icode = wb.m_icode;
        mIn.valE  = wb.m_valE;
        mIn.valM  = wb.m_valM;
        mIn.dstE  = wb.m_dstE;
        mIn.dstM  = wb.m_dstM;
    end

    // ------------------------------------------------------------------
    // State register and W register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            wQ    <= BUBBLE;
        end else begin
            state <= stateNext;
            wQ    <= wNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-W logic
    // The FSM state always agrees with (wQ.stat != AOK). It is kept as an
    // explicit state so the freeze condition is visible by name.
    // ------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        wNext     = wQ;
        unique case (state)
            RUN: begin
                if (wb.w_stall) begin
                    wNext = wQ;
                end else if (wb.w_bubble) begin
                    wNext = BUBBLE;
                end else begin
                    wNext = mIn;
                    // Any non-AOK status freezes the stage as soon as it
                    // reaches W, whether or not it is marked valid.
                    if (wb.m_stat != STAT_AOK) begin
                        stateNext = STOP;
                    end
                end
            end
            STOP: begin
                // Only reset leaves STOP. Inputs and control are ignored.
                stateNext = STOP;
                wNext     = wQ;
            end
            default: begin
                stateNext = RUN;
                wNext     = BUBBLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register-file write ports
    // These decode only flopped W fields, so the level-sensitive register
    // file never sees a path from the memory stage or from the control
    // inputs.
    // ------------------------------------------------------------------
    logic writeEn;
    logic dualDst;

    assign writeEn = wQ.valid && (wQ.stat == STAT_AOK);
    // popq %rsp: E and M name the same register. M (the loaded value) wins.
    assign dualDst = (wQ.dstE == wQ.dstM) && (wQ.dstM != REG_NONE);

    assign wb.dstM = writeEn ? wQ.dstM : REG_NONE;
    assign wb.dstE = (writeEn && !dualDst) ? wQ.dstE : REG_NONE;
    // The data ports always show the register contents. Only the indices gate
    // the write.
    assign wb.valE = wQ.valE;
    assign wb.valM = wQ.valM;

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign wb.w_stat  = wQ.stat;
    assign wb.w_icode = wQ.icode;
    assign wb.halted  = (wQ.stat != STAT_AOK);
    assign wb.wbState = state;

    // ------------------------------------------------------------------
    // Retired-instruction counter
    // An instruction is counted on the edge where it leaves W: it is valid,
    // AOK, and W is not being held. A stalled instruction is counted later,
    // when it finally moves on. In STOP the count is held because W is
    // frozen.
    // ------------------------------------------------------------------
`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retiredQ;
    logic             retireNow;

    assign retireNow = writeEn && (state == RUN) && !wb.w_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retiredQ <= '0;
        end else if (retireNow) begin
            // Wraps modulo 2^CNT_W.
            retiredQ <= retiredQ + CNT_W'(1);
        end
    end

    assign wb.retired = retiredQ;
`else
    assign wb.retired = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Drives instruction sequences into wb_stage and compares the write ports,
// status and retired counter against expected values. A small model of the
// W register produces those values.
// ---------------------------------------------------------------------------
module tb_wb_stage;

    localparam int CNT_W = 4;
    localparam int EW    = 4 + 64 + 4 + 64 + 2 + 4 + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_stage_if #(.CNT_W(CNT_W)) bus ();

    wb_stage #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    // reference model of the W register
    logic             mdl_valid;
    logic [1:0]       mdl_stat;
    logic [3:0]       mdl_icode;
    logic [63:0]      mdl_valE;
    logic [63:0]      mdl_valM;
    logic [3:0]       mdl_dstE;
    logic [3:0]       mdl_dstM;
    logic [CNT_W-1:0] mdl_cnt;

    task automatic model_bubble();
        mdl_valid = 1'b0;
        mdl_stat  = 2'd0;
        mdl_icode = 4'h1;
        mdl_valE  = 64'd0;
        mdl_valM  = 64'd0;
        mdl_dstE  = 4'hf;
        mdl_dstM  = 4'hf;
    endtask

    // Advance the model by one rising edge, using the inputs currently driven.
    task automatic model_edge();
        logic ret;
        ret = mdl_valid && (mdl_stat == 2'd0) && !bus.w_stall;
        if (!rst_n) begin
            model_bubble();
            mdl_cnt = '0;
        end else begin
`ifdef WB_RETIRE_CNT_EN
            if (ret) mdl_cnt = mdl_cnt + 1'b1;
`endif
            if (mdl_stat != 2'd0) begin
                // frozen: the model holds
            end else if (bus.w_stall) begin
                // stall: the model holds
            end else if (bus.w_bubble) begin
                model_bubble();
            end else begin
                mdl_valid = bus.m_valid;
                mdl_stat  = bus.m_stat;
                mdl_icode = bus.m_icode;
                mdl_valE  = bus.m_valE;
                mdl_valM  = bus.m_valM;
                mdl_dstE  = bus.m_dstE;
                mdl_dstM  = bus.m_dstM;
            end
        end
    endtask

    function automatic logic [EW-1:0] model_out();
        logic [3:0] de;
        logic [3:0] dm;
        if (!mdl_valid || mdl_stat != 2'd0) begin
            de = 4'hf;
            dm = 4'hf;
        end else begin
            dm = mdl_dstM;
            if (mdl_dstE == mdl_dstM && mdl_dstM != 4'hf) de = 4'hf;
            else de = mdl_dstE;
        end
        return {de, mdl_valE, dm, mdl_valM, mdl_stat, mdl_icode, (mdl_stat != 2'd0)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drv(input logic v, input logic [1:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic [3:0] de, input logic [3:0] dm);
        bus.m_valid = v;
        bus.m_stat  = st;
        bus.m_icode = ic;
        bus.m_valE  = ve;
        bus.m_valM  = vm;
        bus.m_dstE  = de;
        bus.m_dstM  = dm;
    endtask

    task automatic drv_idle();
        drv(1'b0, 2'd0, 4'h1, 64'd0, 64'd0, 4'hf, 4'hf);
    endtask

    task automatic ctl(input logic stall, input logic bubble);
        bus.w_stall  = stall;
        bus.w_bubble = bubble;
    endtask

    // Push the expected result of the coming edge, clock it, then pop the
    // expected result and compare it with the DUT outputs.
    task automatic step();
        logic [EW-1:0] exp_v;
        logic [EW-1:0] got_v;
        model_edge();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        got_v = {bus.dstE, bus.valE, bus.dstM, bus.valM, bus.w_stat, bus.w_icode, bus.halted};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL wb_out t=%0t dstE %h/%h valE %h/%h dstM %h/%h valM %h/%h stat %h/%h icode %h/%h halted %b/%b (got/exp)",
                     $time, got_v[142:139], exp_v[142:139], got_v[138:75], exp_v[138:75],
                     got_v[74:71], exp_v[74:71], got_v[70:7], exp_v[70:7],
                     got_v[6:5], exp_v[6:5], got_v[4:1], exp_v[4:1], got_v[0], exp_v[0]);
        end
        checks++;
        if (bus.retired !== mdl_cnt) begin
            errors++;
            $display("FAIL retired t=%0t got %0d exp %0d", $time, bus.retired, mdl_cnt);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drv_idle();
        ctl(1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.dstE !== 4'hf || bus.dstM !== 4'hf || bus.w_icode !== 4'h1 ||
            bus.halted !== 1'b0 || bus.retired !== '0 || bus.w_stat !== 2'd0) begin
            errors++;
            $display("FAIL reset_state dstE %h dstM %h icode %h halted %b retired %0d stat %0d exp f f 1 0 0 0",
                     bus.dstE, bus.dstM, bus.w_icode, bus.halted, bus.retired, bus.w_stat);
        end
    endtask

    task automatic test_irmovq();
        logic [CNT_W-1:0] exp_r;
        drv(1'b1, 2'd0, 4'h3, 64'h1234, 64'd0, 4'h3, 4'hf);
        step();
        checks++;
        if (bus.dstE !== 4'h3 || bus.valE !== 64'h1234 || bus.dstM !== 4'hf) begin
            errors++;
            $display("FAIL irmovq dstE %h valE %h dstM %h exp 3 1234 f", bus.dstE, bus.valE, bus.dstM);
        end
        drv_idle();
        step();
`ifdef WB_RETIRE_CNT_EN
        exp_r = CNT_W'(1);
`else
        exp_r = '0;
`endif
        checks++;
        if (bus.retired !== exp_r) begin
            errors++;
            $display("FAIL irmovq_retire got %0d exp %0d", bus.retired, exp_r);
        end
    endtask

    task automatic test_popq();
        drv(1'b1, 2'd0, 4'hb, 64'h108, 64'hab, 4'h4, 4'h4);
        step();
        checks++;
        if (bus.dstE !== 4'hf || bus.dstM !== 4'h4 || bus.valM !== 64'hab) begin
            errors++;
            $display("FAIL popq_rsp dstE %h dstM %h valM %h exp f 4 ab", bus.dstE, bus.dstM, bus.valM);
        end
        drv_idle();
        step();
    endtask

    task automatic test_stall_bubble();
        drv(1'b1, 2'd0, 4'h6, 64'h55, 64'd0, 4'h2, 4'hf);
        step();
        ctl(1'b1, 1'b1);
        drv(1'b1, 2'd0, 4'h3, 64'h77, 64'd0, 4'h7, 4'hf);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.dstE !== 4'h2 || bus.valE !== 64'h55) begin
            errors++;
            $display("FAIL stall_hold dstE %h valE %h exp 2 55", bus.dstE, bus.valE);
        end
        ctl(1'b0, 1'b1);
        step();
        checks++;
        if (bus.dstE !== 4'hf) begin
            errors++;
            $display("FAIL bubble_only dstE %h exp f", bus.dstE);
        end
        ctl(1'b0, 1'b0);
        drv_idle();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            drv(1'($urandom_range(0, 1)), 2'd0, 4'($urandom_range(0, 11)),
                {$urandom, $urandom}, {$urandom, $urandom},
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            ctl($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            step();
        end
        ctl(1'b0, 1'b0);
        drv_idle();
        step();
    endtask

    task automatic test_reset_stall();
        drv(1'b1, 2'd0, 4'h6, 64'h99, 64'd0, 4'h6, 4'hf);
        step();
        ctl(1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.dstE !== 4'hf || bus.valE !== 64'd0) begin
            errors++;
            $display("FAIL reset_over_stall dstE %h valE %h exp f 0", bus.dstE, bus.valE);
        end
        rst_n = 1'b1;
        ctl(1'b0, 1'b0);
        drv_idle();
        step();
    endtask

    task automatic test_wrap();
        logic [CNT_W-1:0] exp_r;
        rst_n = 1'b0;
        drv_idle();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drv(1'b1, 2'd0, 4'h3, 64'(i), 64'd0, 4'(i % 15), 4'hf);
            step();
        end
        drv_idle();
        step();
`ifdef WB_RETIRE_CNT_EN
        exp_r = CNT_W'(1);
`else
        exp_r = '0;
`endif
        checks++;
        if (bus.retired !== exp_r) begin
            errors++;
            $display("FAIL retire_wrap got %0d exp %0d", bus.retired, exp_r);
        end
    endtask

    task automatic test_fault();
        drv(1'b1, 2'd2, 4'h5, 64'h0, 64'hdead, 4'hf, 4'h1);
        step();
        checks++;
        if (bus.dstM !== 4'hf || bus.w_stat !== 2'd2 || bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL adr_fault dstM %h stat %0d halted %b exp f 2 1", bus.dstM, bus.w_stat, bus.halted);
        end
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 11)),
                {$urandom, $urandom}, {$urandom, $urandom},
                4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)));
            ctl($urandom_range(0, 1) == 1, 1'b1);
            step();
        end
        checks++;
        if (bus.w_stat !== 2'd2 || bus.valM !== 64'hdead || bus.dstE !== 4'hf) begin
            errors++;
            $display("FAIL stop_frozen stat %0d valM %h dstE %h exp 2 dead f", bus.w_stat, bus.valM, bus.dstE);
        end
        rst_n = 1'b0;
        ctl(1'b0, 1'b0);
        step();
        checks++;
        if (bus.halted !== 1'b0 || bus.w_stat !== 2'd0 || bus.dstM !== 4'hf || bus.w_icode !== 4'h1 ||
            bus.retired !== '0) begin
            errors++;
            $display("FAIL reset_from_stop halted %b stat %0d dstM %h icode %h retired %0d exp 0 0 f 1 0",
                     bus.halted, bus.w_stat, bus.dstM, bus.w_icode, bus.retired);
        end
        rst_n = 1'b1;
        drv(1'b1, 2'd0, 4'h3, 64'h42, 64'd0, 4'h5, 4'hf);
        step();
        drv_idle();
        step();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        model_bubble();
        mdl_cnt = '0;
        drv_idle();
        ctl(1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_irmovq();
        test_popq();
        test_stall_bubble();
        test_random();
        test_reset_stall();
        test_wrap();
        test_fault();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover %0d entries exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
